// File: rtl/letter_fx_ctrl.sv
// letter_fx_ctrl
// Frame-synchronous effect controller for the three-letter overlay renderer.
// A debounced mode button cycles SOLID -> BLINK -> SEQ -> CYCLE. Every
// frame_tick the controller produces the renderer colour and a per-letter
// enable mask. All outputs move only on frame_tick, so a frame never tears.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset (release synchronised inside)
//   frame_tick one-clock pulse at the start of vertical blank
//   btn_mode   raw bouncing pushbutton, active-high, asynchronous
//   sw_color   user colour switches {R,G,B}, sampled on frame_tick
//   color      registered colour to the renderer
//   letter_en  registered per-letter enable: bit2 = R, bit1 = E, bit0 = L
//   mode       registered applied mode (0 SOLID, 1 BLINK, 2 SEQ, 3 CYCLE);
//              this is also the controller state
module letter_fx_ctrl #(
    parameter int unsigned DEB_CYCLES   = 500000,
    parameter int unsigned BLINK_FRAMES = 30,
    parameter int unsigned STEP_FRAMES  = 60
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       btn_mode,
    input  logic [2:0] sw_color,
    output logic [2:0] color,
    output logic [2:0] letter_en,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_BLINK = 2'd1,
        MODE_SEQ   = 2'd2,
        MODE_CYCLE = 2'd3
    } mode_t;

    localparam logic [19:0] DEB_LAST   = 20'(DEB_CYCLES - 1);
    localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);
    localparam logic [7:0]  STEP_LAST  = 8'(STEP_FRAMES - 1);

    // Reset asserts asynchronously but releases on a clock edge, so every
    // other flop leaves reset on the same clean edge.
    logic rst_meta_q, rst_sync_q;
    logic rst_n_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    assign rst_n_i = rst_sync_q;

    logic        btn_meta_q, btn_s_q;
    logic        btn_db_q, btn_db_d;
    logic [19:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]  pend_q, pend_d;
    logic        press;
    mode_t       mode_q, mode_d;
    logic [7:0]  fcnt_q, fcnt_d;
    logic [2:0]  color_q, color_d;
    logic [2:0]  en_q, en_d;

    // Debouncer: a new level is accepted only after DEB_CYCLES consecutive
    // clocks of disagreement; any agreement restarts the count.
    always_comb begin
        btn_db_d  = btn_db_q;
        deb_cnt_d = '0;
        press     = 1'b0;
        if (btn_s_q != btn_db_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                btn_db_d = btn_s_q;
                press    = btn_s_q;   // only the 0->1 acceptance is a press
            end else begin
                deb_cnt_d = deb_cnt_q + 20'd1;
            end
        end
        pend_d = pend_q + {1'b0, press};
    end

    // Mode / effect next-state. The mode register is the FSM state; it only
    // moves on frame_tick and takes pend_q, i.e. the value before any press
    // landing in the same cycle.
    always_comb begin
        mode_d  = mode_q;
        fcnt_d  = fcnt_q;
        color_d = color_q;
        en_d    = en_q;
        if (frame_tick) begin
            mode_d = mode_t'(pend_q);
            if (pend_q != mode_q) begin
                fcnt_d = '0;
                unique case (mode_t'(pend_q))
                    MODE_SOLID: begin color_d = sw_color; en_d = 3'b111; end
                    MODE_BLINK: begin color_d = sw_color; en_d = 3'b111; end
                    MODE_SEQ:   begin color_d = sw_color; en_d = 3'b100; end
                    MODE_CYCLE: begin
                        color_d = (sw_color != 3'b000) ? sw_color : 3'b001;
                        en_d    = 3'b111;
                    end
                    default: ;
                endcase
            end else begin
                unique case (mode_q)
                    MODE_SOLID: begin
                        color_d = sw_color;
                        en_d    = 3'b111;
                        fcnt_d  = '0;
                    end
                    MODE_BLINK: begin
                        color_d = sw_color;
                        if (fcnt_q == BLINK_LAST) begin
                            fcnt_d = '0;
                            en_d   = ~en_q;   // mask is always 111 or 000
                        end else begin
                            fcnt_d = fcnt_q + 8'd1;
                        end
                    end
                    MODE_SEQ: begin
                        color_d = sw_color;
                        if (fcnt_q == STEP_LAST) begin
                            fcnt_d = '0;
                            en_d   = {en_q[0], en_q[2:1]};   // R -> E -> L -> R
                        end else begin
                            fcnt_d = fcnt_q + 8'd1;
                        end
                    end
                    MODE_CYCLE: begin
                        en_d = 3'b111;
                        if (fcnt_q == STEP_LAST) begin
                            fcnt_d  = '0;
                            color_d = (color_q == 3'b111) ? 3'b001 : color_q + 3'd1;
                        end else begin
                            fcnt_d = fcnt_q + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            btn_meta_q <= 1'b0;
            btn_s_q    <= 1'b0;
            btn_db_q   <= 1'b0;
            deb_cnt_q  <= '0;
            pend_q     <= 2'd0;
        end else begin
            btn_meta_q <= btn_mode;
            btn_s_q    <= btn_meta_q;
            btn_db_q   <= btn_db_d;
            deb_cnt_q  <= deb_cnt_d;
            pend_q     <= pend_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mode_q  <= MODE_SOLID;
            fcnt_q  <= '0;
            color_q <= 3'b111;
            en_q    <= 3'b111;
        end else begin
            mode_q  <= mode_d;
            fcnt_q  <= fcnt_d;
            color_q <= color_d;
            en_q    <= en_d;
        end
    end

    assign color     = color_q;
    assign letter_en = en_q;
    assign mode      = mode_q;

endmodule

// File: doc/letter_fx_ctrl.md
# letter_fx_ctrl

Frame-synchronous effect controller for the three-letter 16x16 overlay renderer (letters R at x=300, E at x=400, L at x=500, row 238). It debounces a mode pushbutton and cycles through four display modes: solid, blink, sequential, colour-cycle. Every frame it produces the renderer's 3-bit `color` and a per-letter enable mask. It sits between board I/O and the letter renderer. All outputs change only on `frame_tick`, so a frame never tears.

## Interface
- `DEB_CYCLES`, default 500000: consecutive stable clocks needed to accept a new button level (10 ms at 50 MHz); range 1..2^20-1.
- `BLINK_FRAMES`, default 30: frames per blink half-period; range 1..255.
- `STEP_FRAMES`, default 60: frames per sequence or colour step; range 1..255.
- `clk` input 1: single system clock; all logic is on the rising edge.
- `reset_n` input 1: reset, asynchronous and active-low.
- `frame_tick` input 1: one-clock pulse once per frame, asserted at the start of vertical blank.
- `btn_mode` input 1: raw, asynchronous, bouncing pushbutton; active-high.
- `sw_color` input 3: user colour switches {R,G,B}.
- `color` output 3: colour to the renderer; registered.
- `letter_en` output 3: per-letter enable, registered. bit0 = L (x=500), bit1 = E (x=400), bit2 = R (x=300). The renderer ANDs each letter's hit with its bit.
- `mode` output 2: current applied mode; registered.

## Operation
- **Input synchroniser:** `btn_mode` passes through a 2-FF synchroniser to give `btn_s`.
- **Debouncer:** holds a stable level `btn_db` and a counter.
  - Counter increments while `btn_s != btn_db`.
  - Counter clears whenever `btn_s == btn_db`.
  - When the counter reaches `DEB_CYCLES-1`, `btn_db <= btn_s` and the counter clears.
- **Press event:** one-clock pulse on a 0->1 transition of `btn_db`. Releases generate nothing.
- **Pending mode:** `pend` (2 bits) increments modulo 4 on each press event; 3 wraps to 0. Any number of presses within one frame accumulate.
- **Mode encoding:** 0 SOLID, 1 BLINK, 2 SEQ, 3 CYCLE.
- **On each `frame_tick`:**
  - `mode <= pend`, using the value of `pend` before any press in the same cycle.
  - If `pend != mode` (mode entry), clear the frame counter `fcnt` (8 bits) and apply the entry values below.
  - Otherwise, run the per-mode update below.
- **SOLID:** `color <= sw_color`, `letter_en <= 111`. `fcnt` is unused and held at 0.
- **BLINK:** `color <= sw_color`.
  - Entry: phase = on, `letter_en <= 111`.
  - Per tick: if `fcnt == BLINK_FRAMES-1`, then `fcnt <= 0` and `letter_en` toggles between 111 and 000; else `fcnt++`.
- **SEQ:** `color <= sw_color`.
  - Entry: `letter_en <= 100` (R).
  - Each step: `letter_en` rotates right, 100 -> 010 -> 001 -> 100. Exactly one bit is ever set.
  - Step rule: step when `fcnt == STEP_FRAMES-1` (then `fcnt <= 0`); else `fcnt++`.
- **CYCLE:** `letter_en <= 111`.
  - Entry: `color <= (sw_color != 000) ? sw_color : 001`.
  - Each step (same step rule as SEQ): `color` increments, with 7 wrapping to 1. 000 is never produced.
- **Switch sampling:** `sw_color` is sampled only on `frame_tick`. A value of 000 in SOLID/BLINK/SEQ is passed through, so the letters are invisible; this is legal.
- **Reset (async, any time including mid-frame or mid-debounce):** all registers take their reset values immediately.
  - Synchroniser FFs = 0, `btn_db` = 0, debounce counter = 0, `pend` = 0, `fcnt` = 0.
  - Outputs: `mode` = 0, `color` = 111, `letter_en` = 111.
  - Reset release is synchronised internally, so the first active edge is clean.

## Timing
- **Output latency:** outputs update on the clock edge that samples `frame_tick` high and are visible the following cycle. They are constant between ticks.
- **Button latency:** a clean press is 2 synchroniser clocks plus `DEB_CYCLES` clocks to the press pulse. It is applied at the next `frame_tick` strictly after the pulse.
- **Press and tick in the same cycle:** the press is counted into `pend` and applied at the following tick.
- **Bounce rejection:** a glitch shorter than `DEB_CYCLES` consecutive clocks produces no event.
- **Period arithmetic:** blink half-period = `BLINK_FRAMES` ticks; step period = `STEP_FRAMES` ticks. A value of 1 changes the output every tick.
- **Missing ticks:** with `frame_tick` absent, outputs never change, even if presses occur.

## Test plan
Bench parameters: `DEB_CYCLES=4`, `BLINK_FRAMES=2`, `STEP_FRAMES=3`.
- **Reset:** assert `reset_n`=0 mid-operation -> `color`=111, `letter_en`=111, `mode`=0 in the same cycle. After release, with `sw_color`=101, the first tick gives `color`=101, `letter_en`=111.
- **Debounce:** `btn_mode` high for 3 clocks then low -> `mode` remains 0 after 2 ticks. High for 10 clocks -> `mode`=1 at the next tick, not before.
- **Blink:** in BLINK -> `letter_en` sequence over ticks from entry is 111, 111, 000, 000, 111.
- **Sequence:** two presses from reset, then ticks -> `mode`=2, `letter_en` = 100 ×3 ticks, 010 ×3, 001 ×3, 100.
- **Colour cycle:** enter CYCLE with `sw_color`=000 -> `color`=001. Stepping continues through 111 -> 001, never 000.
- **Accumulation and coincidence:** 5 presses in one frame -> `mode`=1. A press in the same cycle as a tick -> applied at the next tick.
